// File: rtl/alu_pipe.sv
// Execution unit: single-cycle ALU plus an iterative shift-add multiplier behind a
// valid/ready handshake with one output register, flush and back-pressure.
module alu_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [XLEN-1:0]  value_1,
    input  logic [XLEN-1:0]  value_2,
    input  logic [TAG_W-1:0] des_input,
    input  logic             is_branch_input,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] des_rob,
    output logic [TAG_W-1:0] des_rs,
    output logic [XLEN-1:0]  result,
    output logic             is_branch_out
);

    localparam int unsigned SH_W = $clog2(XLEN);
    localparam int unsigned CntW = SH_W + 1;
    localparam logic [CntW-1:0] CountInit = CntW'(XLEN);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpAnd  = 5'b00001;
    localparam logic [4:0] OpOr   = 5'b00010;
    localparam logic [4:0] OpSll  = 5'b00011;
    localparam logic [4:0] OpSrl  = 5'b00100;
    localparam logic [4:0] OpSlt  = 5'b00101;
    localparam logic [4:0] OpSltu = 5'b00110;
    localparam logic [4:0] OpSra  = 5'b00111;
    localparam logic [4:0] OpSub  = 5'b01000;
    localparam logic [4:0] OpXor  = 5'b01001;
    localparam logic [4:0] OpEq   = 5'b01010;
    localparam logic [4:0] OpGe   = 5'b01011;
    localparam logic [4:0] OpNe   = 5'b01100;
    localparam logic [4:0] OpGeu  = 5'b01101;
    localparam logic [4:0] OpJalr = 5'b10001;
    localparam logic [4:0] OpMul  = 5'b10010;
    localparam logic [4:0] OpLt   = 5'b11010;
    localparam logic [4:0] OpLtu  = 5'b11011;

    typedef enum logic [1:0] {StIdle, StMulBusy, StMulDone} state_e;

    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] des_q, des_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             br_q, br_d;

    logic [CntW-1:0]  count_q, count_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic             mbr_q, mbr_d;

    logic            slot_free;
    logic            accept;
    logic [SH_W-1:0] shamt;
    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] alu_res;

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign shamt     = value_2[SH_W-1:0];
    assign lt_s      = $signed(value_1) < $signed(value_2);
    assign lt_u      = value_1 < value_2;
    assign eq        = value_1 == value_2;

    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd, OpJalr: alu_res = value_1 + value_2;
            OpSub:         alu_res = value_1 - value_2;
            OpAnd:         alu_res = value_1 & value_2;
            OpOr:          alu_res = value_1 | value_2;
            OpXor:         alu_res = value_1 ^ value_2;
            OpSll:         alu_res = value_1 << shamt;
            OpSrl:         alu_res = value_1 >> shamt;
            OpSra:         alu_res = XLEN'($signed(value_1) >>> shamt);
            OpSlt, OpLt:   alu_res = XLEN'(lt_s);
            OpSltu, OpLtu: alu_res = XLEN'(lt_u);
            OpEq:          alu_res = XLEN'(eq);
            OpNe:          alu_res = XLEN'(!eq);
            OpGe:          alu_res = XLEN'(!lt_s);
            OpGeu:         alu_res = XLEN'(!lt_u);
            default:       alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept && op == OpMul) state_d = StMulBusy;
            StMulBusy: if (count_q == CntOne) state_d = StMulDone;
            StMulDone: if (slot_free) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        in_ready = (state_q == StIdle) && slot_free;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        des_d       = des_q;
        result_d    = result_q;
        br_d        = br_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mtag_d      = mtag_q;
        mbr_d       = mbr_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        mcand_d  = value_1;
                        mplier_d = value_2;
                        acc_d    = '0;
                        count_d  = CountInit;
                        mtag_d   = des_input;
                        mbr_d    = is_branch_input;
                    end else begin
                        out_valid_d = 1'b1;
                        des_d       = des_input;
                        result_d    = alu_res;
                        br_d        = is_branch_input;
                    end
                end
            end
            StMulBusy: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CntOne;
            end
            StMulDone: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    des_d       = mtag_q;
                    result_d    = acc_q;
                    br_d        = mbr_q;
                end
            end
            default: ;
        endcase

        // Flush kills the valid bit only; the visible fields keep their last value.
        if (flush) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            des_d       = des_q;
            result_d    = result_q;
            br_d        = br_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            des_q       <= '0;
            result_q    <= '0;
            br_q        <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mtag_q      <= '0;
            mbr_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            des_q       <= des_d;
            result_q    <= result_d;
            br_q        <= br_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mtag_q      <= mtag_d;
            mbr_q       <= mbr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign des_rob       = des_q;
    assign des_rs        = des_q;
    assign result        = result_q;
    assign is_branch_out = br_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, random back-to-back ops
// against an arithmetic reference, and hand-written multiplier/stall/flush/reset sequences.
module tb_alu_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] value_1, value_2, result;
    logic [2:0]  des_input, des_rob, des_rs;
    logic        is_branch_input, is_branch_out;

    logic        s_in_valid, s_in_ready, s_out_valid;
    logic [4:0]  s_op;
    logic [15:0] s_v1, s_v2, s_result;
    logic [4:0]  s_des, s_des_rob, s_des_rs;
    logic        s_br, s_br_out;

    alu_pipe #(.XLEN(32), .TAG_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .value_1(value_1), .value_2(value_2), .des_input(des_input),
        .is_branch_input(is_branch_input), .out_valid(out_valid), .out_ready(out_ready),
        .des_rob(des_rob), .des_rs(des_rs), .result(result), .is_branch_out(is_branch_out)
    );

    alu_pipe #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .value_1(s_v1), .value_2(s_v2), .des_input(s_des),
        .is_branch_input(s_br), .out_valid(s_out_valid), .out_ready(1'b1),
        .des_rob(s_des_rob), .des_rs(s_des_rs), .result(s_result), .is_branch_out(s_br_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
        logic        br;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [4:0] ops[17] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                            5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h11, 5'h1A, 5'h1B};

    function automatic vec_t mk(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] t, input logic br, input logic [31:0] e);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.tag = t; v.br = br; v.exp = e;
        return v;
    endfunction

    // Reference: plain 64-bit arithmetic on the opcode's meaning.
    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        int     sh;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        p  = 64'(a) * 64'(b);
        case (o)
            5'h00, 5'h11: return 32'(64'(a) + 64'(b));
            5'h08:        return 32'(64'(a) + 64'(~b) + 64'd1);
            5'h01:        return a & b;
            5'h02:        return a | b;
            5'h09:        return a ^ b;
            5'h03:        return 32'(64'(a) * (64'd1 << sh));
            5'h04:        return 32'(64'(a) / (64'd1 << sh));
            5'h07:        return 32'(sa >>> sh);
            5'h05, 5'h1A: return {31'b0, sa < sb};
            5'h06, 5'h1B: return {31'b0, a < b};
            5'h0A:        return {31'b0, a == b};
            5'h0B:        return {31'b0, sa >= sb};
            5'h0C:        return {31'b0, a != b};
            5'h0D:        return {31'b0, a >= b};
            5'h12:        return p[31:0];
            default:      return 32'h0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] t, input logic br);
        op = o; value_1 = a; value_2 = b; des_input = t; is_branch_input = br;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) check("issue_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic mul_check(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] t, input logic br);
        int   lat;
        logic rdy_hi;
        issue(5'h12, a, b, t, br);
        lat = 0;
        rdy_hi = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (in_ready) rdy_hi = 1'b1;
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'd33);
        check({nm, "_ready_low"}, rdy_hi, 0);
        check({nm, "_result"}, result, ref_alu(5'h12, a, b));
        check({nm, "_tag"}, des_rob, t);
    endtask

    task automatic s_mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] t,
                         input logic [15:0] e);
        int lat;
        s_op = 5'h12; s_v1 = a; s_v2 = b; s_des = t; s_br = 1'b0; s_in_valid = 1'b1;
        check("x16_mul_ready", s_in_ready, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("x16_mul_busy_ready", s_in_ready, 0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (s_out_valid) begin
                lat = c;
                break;
            end
        end
        check("x16_mul_latency", 64'(lat), 64'd17);
        check("x16_mul_result", s_result, e);
        check("x16_mul_tag", s_des_rob, t);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [4:0]  o;
        logic [31:0] a, b, e;
        logic [2:0]  t;
        logic        saw;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; value_1 = '0; value_2 = '0; des_input = '0; is_branch_input = 1'b0;
        s_in_valid = 1'b0; s_op = '0; s_v1 = '0; s_v2 = '0; s_des = '0; s_br = 1'b0;

        vecs.push_back(mk(5'h08, 32'h0,        32'h1,  3'd1, 1'b0, 32'hFFFF_FFFF));
        vecs.push_back(mk(5'h07, 32'h8000_0000, 32'h24, 3'd2, 1'b0, 32'hF800_0000));
        vecs.push_back(mk(5'h05, 32'hFFFF_FFFF, 32'h1,  3'd3, 1'b1, 32'h1));
        vecs.push_back(mk(5'h06, 32'hFFFF_FFFF, 32'h1,  3'd4, 1'b0, 32'h0));
        vecs.push_back(mk(5'h1F, 32'h1234,      32'h1,  3'd7, 1'b1, 32'h0));
        vecs.push_back(mk(5'h0A, 32'h5,         32'h5,  3'd0, 1'b1, 32'h1));
        vecs.push_back(mk(5'h0B, 32'hFFFF_FFFE, 32'h1,  3'd5, 1'b1, 32'h0));
        vecs.push_back(mk(5'h0D, 32'hFFFF_FFFE, 32'h1,  3'd6, 1'b1, 32'h1));
        vecs.push_back(mk(5'h1A, 32'hFFFF_FFFE, 32'h1,  3'd1, 1'b1, 32'h1));
        vecs.push_back(mk(5'h1B, 32'hFFFF_FFFE, 32'h1,  3'd2, 1'b1, 32'h0));
        vecs.push_back(mk(5'h03, 32'h1,         32'h21, 3'd3, 1'b0, 32'h2));
        vecs.push_back(mk(5'h04, 32'h8000_0000, 32'h1F, 3'd4, 1'b0, 32'h1));
        vecs.push_back(mk(5'h11, 32'd10,        32'd20, 3'd5, 1'b1, 32'd30));
        vecs.push_back(mk(5'h0C, 32'h3,         32'h3,  3'd6, 1'b1, 32'h0));
        vecs.push_back(mk(5'h09, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 1'b0, 32'h0FF0_0FF0));
        vecs.push_back(mk(5'h02, 32'hF000_0000, 32'h0000_000F, 3'd0, 1'b0, 32'hF000_000F));

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_des_rob", des_rob, 0);
        check("rst_des_rs", des_rs, 0);
        check("rst_branch", is_branch_out, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors, one cycle after accept
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].br);
            check("vec_out_valid", out_valid, 1);
            check("vec_result", result, vecs[i].exp);
            check("vec_des_rob", des_rob, vecs[i].tag);
            check("vec_des_rs", des_rs, vecs[i].tag);
            check("vec_branch", is_branch_out, vecs[i].br);
        end

        // Random back-to-back single-cycle ops
        in_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            o = ops[$urandom_range(0, 16)];
            if ($urandom_range(0, 9) == 0) o = 5'($urandom_range(0, 31));
            if (o == 5'h12) o = 5'h00;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            t = 3'($urandom);
            e = ref_alu(o, a, b);
            op = o; value_1 = a; value_2 = b; des_input = t; is_branch_input = 1'($urandom);
            #1;
            check("b2b_in_ready", in_ready, 1);
            @(posedge clk); #1;
            check("b2b_out_valid", out_valid, 1);
            check("b2b_result", result, e);
            check("b2b_tag", des_rob, t);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_out_valid", out_valid, 0);

        // Back-pressure: ADD tag 5 held, AND tag 6 waits
        out_ready = 1'b0;
        issue(5'h00, 32'd1, 32'd2, 3'd5, 1'b0);
        check("bp_first_valid", out_valid, 1);
        op = 5'h01; value_1 = 32'h0000_F0F0; value_2 = 32'h0000_FF00; des_input = 3'd6;
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_hold_tag", des_rob, 5);
            check("bp_hold_result", result, 3);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_tag", des_rs, 6);
        check("bp_second_result", result, 32'h0000_F000);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        // Multiplier
        mul_check("mul_a", 32'h0001_0003, 32'h0000_0005, 3'd2, 1'b0);
        check("mul_a_const", result, 32'h0005_000F);
        mul_check("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b1);
        check("mul_ones_const", result, 32'h1);
        for (int i = 0; i < 3; i++) mul_check("mul_rand", $urandom, $urandom, 3'($urandom), 1'b0);

        // Completion while the bus stalls
        @(posedge clk); #1;
        out_ready = 1'b0;
        mul_check("mul_stall", 32'd7, 32'd9, 3'd3, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_result", result, 63);
            check("stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", in_ready, 1);
        @(posedge clk); #1;
        check("stall_consumed", out_valid, 0);

        // Reset in the middle of a multiply
        issue(5'h12, 32'h1234, 32'h5678, 3'd7, 1'b1);
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_des_rob", des_rob, 0);
        check("midrst_branch", is_branch_out, 0);
        check("midrst_in_ready", in_ready, 1);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        check("midrst_no_stale", saw, 0);

        // Flush a held result: valid drops, fields stay
        out_ready = 1'b0;
        issue(5'h00, 32'd100, 32'd23, 3'd4, 1'b1);
        check("fl_held_result", result, 123);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_held_valid", out_valid, 0);
        check("fl_held_keep_result", result, 123);
        check("fl_held_keep_tag", des_rob, 4);
        check("fl_held_keep_branch", is_branch_out, 1);

        // Flush mid-multiply, then flush alongside an ADD request
        out_ready = 1'b1;
        issue(5'h12, 32'd3, 32'd5, 3'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_mul_idle_ready", in_ready, 1);
        op = 5'h00; value_1 = 32'd9; value_2 = 32'd9; des_input = 3'd3; in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        check("fl_nothing_appears", saw, 0);
        issue(5'h00, 32'd7, 32'd8, 3'd1, 1'b0);
        check("fl_next_add_valid", out_valid, 1);
        check("fl_next_add_result", result, 15);
        check("fl_next_add_tag", des_rob, 1);

        // XLEN=16, TAG_W=5 instance
        s_op = 5'h00; s_v1 = 16'hFFFF; s_v2 = 16'h0002; s_des = 5'h1F; s_br = 1'b1;
        s_in_valid = 1'b1;
        #1;
        check("x16_add_ready", s_in_ready, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("x16_add_valid", s_out_valid, 1);
        check("x16_add_result", s_result, 16'h0001);
        check("x16_add_des_rob", s_des_rob, 5'h1F);
        check("x16_add_des_rs", s_des_rs, 5'h1F);
        check("x16_add_branch", s_br_out, 1);
        @(posedge clk); #1;
        s_mul(16'h1234, 16'h0010, 5'h0A, 16'h2340);
        @(posedge clk); #1;
        s_mul(16'hFFFF, 16'hFFFF, 5'h15, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
